tpu_host_seq: RTL
=================

// Module: tpu_host_seq
// PURPOSE
// - Host-side sequencer directly upstream of the tpuv1 memory-mapped TPU. Takes one job
//   (A rows, B rows, C-init words) as a valid/ready word stream and writes it into tpuv1's
//   A/B/C windows. Issues the multiply kick, waits out the array latency, then reads the
//   16 C words back out onto a valid/ready result stream.
// PARAMETERS
// - DATAW    64  stream and TPU data width
// - ADDRW    16  TPU address width
// - DIM       8  array dimension; job = DIM A words, DIM B words, 2*DIM C words
// - MUL_WAIT 23  cycles between kick write and first C read (>= 3*DIM-1)
// - RD_LAT    1  cycles from tpu_addr valid to tpu_rdata sample (1..3)
// PORTS
// - clk        in   1      clock
// - rst        in   1      asynchronous, active-high reset
// - start      in   1      pulse: begin a job; ignored while busy=1
// - in_data    in   DATAW  job word stream
// - in_valid   in   1      in_data valid
// - in_ready   out  1      sequencer accepts in_data this cycle
// - out_data   out  DATAW  C result word (4 x 16b lanes; row-major, low half first)
// - out_valid  out  1      out_data valid; held until out_ready
// - out_ready  in   1      downstream accepts out_data
// - busy       out  1      job in progress (start accepted to done)
// - done       out  1      1-cycle pulse after the last result word is accepted
// - tpu_addr   out  ADDRW  to tpuv1 addr
// - tpu_r_w    out  1      to tpuv1 r_w (1 = write)
// - tpu_wdata  out  DATAW  to tpuv1 dataIn
// - tpu_rdata  in   DATAW  from tpuv1 dataOut
// BEHAVIOUR
// - Reset values: every output 0; FSM = IDLE; index and wait counters = 0.
// - Reset mid-job aborts it asynchronously. No partial done. The TPU sees r_w=0 from reset on.
// - All tpu_* outputs are registered. tpu_r_w is 1 for exactly one cycle per write.
//   Outside writes: tpu_addr=0, tpu_r_w=0, tpu_wdata=0, except in READ.
// - FSM: IDLE -> LOAD_A -> LOAD_B -> LOAD_C -> KICK -> WAIT -> READ -> IDLE.
// - IDLE: busy=0. start=1 -> LOAD_A, busy<=1, idx<=0.
// - LOAD_A/B/C: in_ready=1.
//   - Each in_valid&&in_ready beat registers a write with tpu_wdata<=in_data.
//   - Address = base + 8*idx. Base: A 16'h0100, B 16'h0200, C 16'h0300.
//   - idx counts 0..DIM-1 for A/B and 0..2*DIM-1 for C; it is cleared on each state change.
//   - Throughput is one beat per cycle. Gaps in in_valid stall without side effects.
// - KICK: one cycle, tpu_addr=16'h0400, tpu_r_w=1, tpu_wdata=0; in_ready=0 -> WAIT.
// - WAIT: counts MUL_WAIT cycles with the bus idle, then -> READ with idx<=0.
// - READ, per word k = 0..2*DIM-1:
//   - Drive tpu_addr = 16'h0300 + 8*k, r_w=0.
//   - After RD_LAT cycles, capture tpu_rdata into out_data and set out_valid=1.
//   - Hold until out_ready, then advance k.
//   - One read outstanding at a time. tpu_addr is held stable through the capture.
// - After word 2*DIM-1 is accepted: done=1 for one cycle, busy<=0, return to IDLE.
// - A start arriving on the same cycle as done is ignored.
// - out_valid never drops without out_ready. out_data is stable while out_valid=1 and
//   out_ready=0.
// - in_ready=0 outside the LOAD states. Beats offered there are not consumed.
// CONFIGURATION
// - TPU_SEQ_CLEAR_C_EN defined:
//   - LOAD_C takes no stream words (in_ready=0).
//   - The sequencer itself issues 2*DIM back-to-back writes of 0 to 16'h0300..+8*(2*DIM-1).
//   - A job is then 2*DIM stream words.
// - Undefined: C-init words come from the stream as above; a job is 4*DIM words.
// TESTING
// - Reset check: assert rst mid-LOAD_B -> all outputs 0 in the same cycle; after release
//   the FSM is IDLE and in_ready=0.
// - Full job, in_valid=1 throughout: writes to 0x0100..0x0138, 0x0200..0x0238 and
//   0x0300..0x0378 carry the words in stream order. 0x0400 is written exactly 23 cycles
//   before the first read.
// - Identity A, B=1..64, C=0: the 16 out_data words equal the B rows, and a reference
//   TPU model matches.
// - out_ready toggling 1-0-0-1: out_data holds through the stall, there are no duplicate
//   or dropped words, and done pulses once after the 16th accept.
// - start pulsed during READ -> ignored; busy stays 1 and the job count is unchanged.
// - With TPU_SEQ_CLEAR_C_EN: 16 stream words -> 16 zero writes to the C window with
//   in_ready=0 throughout LOAD_C.

Source files
------------

// File: rtl/tpu_host_seq_if.sv
// Job/result streams, status and tpuv1 bus for the host sequencer.
// master = sequencer side, slave = host/TPU side.
interface tpu_host_seq_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);
  logic             start;
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  start, in_data, in_valid, out_ready, tpu_rdata,
    output in_ready, out_data, out_valid, busy, done, tpu_addr, tpu_r_w, tpu_wdata
  );
  modport slave (
    output start, in_data, in_valid, out_ready, tpu_rdata,
    input  in_ready, out_data, out_valid, busy, done, tpu_addr, tpu_r_w, tpu_wdata
  );
endinterface

// File: rtl/tpu_host_seq.sv
// Host sequencer for tpuv1: streams a job into the A/B/C windows, kicks, reads C back.
// Define TPU_SEQ_CLEAR_C_EN to zero the C window internally instead of streaming C-init words.
module tpu_host_seq #(
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int DIM      = 8,
  parameter int MUL_WAIT = 23,
  parameter int RD_LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  tpu_host_seq_if.master bus
);
  localparam int IW = $clog2(2*DIM);
  localparam int WW = $clog2(MUL_WAIT+1);
  localparam int RW = $clog2(RD_LAT+1);
  localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] KICK_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, KICK, WAIT, READ} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic [RW-1:0]    rcnt, rcnt_n;
  logic             busy, busy_n, done, done_n, ov, ov_n, rw, rw_n;
  logic [DATAW-1:0] od, od_n, wd, wd_n;
  logic [ADDRW-1:0] addr, addr_n;
  logic             beat, c_go;
  logic [DATAW-1:0] c_word;

  function automatic logic [ADDRW-1:0] slot(input logic [ADDRW-1:0] base, input logic [IW-1:0] i);
    return base + (ADDRW'(i) << 3);
  endfunction

`ifdef TPU_SEQ_CLEAR_C_EN
  assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign c_go         = 1'b1;
  assign c_word       = '0;
`else
  assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign c_go         = beat;
  assign c_word       = bus.in_data;
`endif
  assign beat = bus.in_valid && bus.in_ready;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    wcnt_n  = wcnt;
    rcnt_n  = rcnt;
    busy_n  = busy;
    done_n  = 1'b0;
    ov_n    = ov;
    od_n    = od;
    addr_n  = '0;
    rw_n    = 1'b0;
    wd_n    = '0;
    case (state)
      IDLE: begin
        // done is high on the first IDLE cycle; a start there is dropped
        if (bus.start && !done) begin
          state_n = LOAD_A;
          busy_n  = 1'b1;
          idx_n   = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (beat) begin
          rw_n   = 1'b1;
          wd_n   = bus.in_data;
          addr_n = slot((state == LOAD_A) ? A_BASE : B_BASE, idx);
          if (idx == IW'(DIM-1)) begin
            state_n = (state == LOAD_A) ? LOAD_B : LOAD_C;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      LOAD_C: begin
        if (c_go) begin
          rw_n   = 1'b1;
          wd_n   = c_word;
          addr_n = slot(C_BASE, idx);
          if (idx == IW'(2*DIM-1)) begin
            state_n = KICK;
            idx_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      KICK: begin
        rw_n    = 1'b1;
        addr_n  = KICK_ADDR;
        state_n = WAIT;
        wcnt_n  = '0;
      end
      WAIT: begin
        // kick is on the bus in the first WAIT cycle; first read lands MUL_WAIT cycles later
        if (wcnt == WW'(MUL_WAIT-1)) begin
          state_n = READ;
          idx_n   = '0;
          rcnt_n  = '0;
          addr_n  = C_BASE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      READ: begin
        addr_n = slot(C_BASE, idx);
        if (!ov) begin
          if (rcnt == RW'(RD_LAT)) begin
            ov_n = 1'b1;
            od_n = bus.tpu_rdata;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end else if (bus.out_ready) begin
          ov_n = 1'b0;
          if (idx == IW'(2*DIM-1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            idx_n   = '0;
            addr_n  = '0;
          end else begin
            idx_n  = idx + 1'b1;
            addr_n = slot(C_BASE, idx + 1'b1);
            rcnt_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      wcnt  <= '0;
      rcnt  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ov    <= 1'b0;
      od    <= '0;
      addr  <= '0;
      rw    <= 1'b0;
      wd    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      wcnt  <= wcnt_n;
      rcnt  <= rcnt_n;
      busy  <= busy_n;
      done  <= done_n;
      ov    <= ov_n;
      od    <= od_n;
      addr  <= addr_n;
      rw    <= rw_n;
      wd    <= wd_n;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.tpu_addr  = addr;
  assign bus.tpu_r_w   = rw;
  assign bus.tpu_wdata = wd;
endmodule
